riscv_mc_core: RTL and testbench

Parametrised multicycle RV32 integer core: the next-generation replacement for the fixed-memory multicycle CPU used for matrix–vector kernels. Instruction and data memories move outside the core behind req/valid handshakes with variable latency. The core adds branches, jumps, logic ops and a correct `lui`, and exposes the run-complete flag and performance counters to the board top level.

---
 rtl/riscv_mc_core.sv | 208 ++++++++++++++++++++
 tb/tb_riscv_mc_core.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mc_core.sv
// rtl/riscv_mc_core.sv - multicycle RV32 integer core with req/valid instruction and data ports
module riscv_mc_core #(
    parameter int unsigned IMEM_AW  = 10,
    parameter int unsigned DMEM_AW  = 10,
    parameter int unsigned CNT_W    = 16,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] EOF_WORD = 32'hFFFF_FFFF
) (
    input  logic               CLOCK_50,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               imem_valid,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    input  logic [31:0]        dmem_rdata,
    input  logic               dmem_valid,
    output logic               done,
    output logic               illegal,
    output logic [CNT_W-1:0]   clock_count,
    output logic [CNT_W-1:0]   instr_cnt
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [31:0]       imm_q, imm_d, tgt_q, tgt_d, alu_q, alu_d, mdr_q, mdr_d;
    logic              illegal_q, illegal_d;
    logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d, instr_cnt_q, instr_cnt_d;
    logic [31:0]       regs_q [32];
    logic [31:0]       regs_d [32];

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, alu_res;
    logic        supported, br_taken, retire;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];
    assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u  = {ir_q[31:12], 12'b0};
    assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    always_comb begin
        supported = 1'b0;
        case (opcode)
            OP_R:         supported = (funct7 == 7'b0000000 && funct3 inside {3'b000, 3'b111, 3'b110, 3'b010})
                                   || (funct7 == 7'b0100000 && funct3 == 3'b000)
                                   || (funct7 == 7'b0000001 && funct3 == 3'b000);
            OP_ADDI:      supported = (funct3 == 3'b000);
            OP_LW, OP_SW: supported = (funct3 == 3'b010);
            OP_BR:        supported = funct3 inside {3'b000, 3'b001, 3'b100, 3'b101};
            OP_LUI, OP_JAL: supported = 1'b1;
            default:      supported = 1'b0;
        endcase
    end

    always_comb begin
        alu_res = a_q + imm_q;
        if (opcode == OP_LUI) begin
            alu_res = imm_q;
        end else if (opcode == OP_R) begin
            if (funct7 == 7'b0100000)      alu_res = a_q - b_q;
            else if (funct7 == 7'b0000001) alu_res = a_q * b_q;
            else begin
                case (funct3)
                    3'b111:  alu_res = a_q & b_q;
                    3'b110:  alu_res = a_q | b_q;
                    3'b010:  alu_res = {31'b0, $signed(a_q) < $signed(b_q)};
                    default: alu_res = a_q + b_q;
                endcase
            end
        end
    end

    always_comb begin
        case (funct3)
            3'b000:  br_taken = (a_q == b_q);
            3'b001:  br_taken = (a_q != b_q);
            3'b100:  br_taken = $signed(a_q) < $signed(b_q);
            3'b101:  br_taken = $signed(a_q) >= $signed(b_q);
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (imem_valid) state_d = S_DECODE;
            S_DECODE: state_d = (ir_q == EOF_WORD || !supported) ? S_HALT : S_EXEC;
            S_EXEC: begin
                case (opcode)
                    OP_LW, OP_SW:  state_d = S_MEM;
                    OP_BR, OP_JAL: state_d = S_FETCH;
                    default:       state_d = S_WB;
                endcase
            end
            S_MEM:    if (dmem_valid) state_d = (opcode == OP_SW) ? S_FETCH : S_WB;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase
    end

    // imem_req is gated by rst_n so the request drops the instant reset asserts
    always_comb begin
        imem_req = rst_n && (state_q == S_FETCH);
        dmem_req = (state_q == S_MEM);
        dmem_we  = (state_q == S_MEM) && (opcode == OP_SW);
        done     = (state_q == S_HALT);
    end

    always_comb begin
        pc_d = pc_q; ir_d = ir_q; a_d = a_q; b_d = b_q; imm_d = imm_q; tgt_d = tgt_q;
        alu_d = alu_q; mdr_d = mdr_q; illegal_d = illegal_q; regs_d = regs_q; retire = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (imem_valid) begin
                    ir_d = imem_rdata;
                    pc_d = pc_q + 32'd4;
                end
            end
            S_DECODE: begin
                a_d   = regs_q[rs1];
                b_d   = regs_q[rs2];
                tgt_d = (pc_q - 32'd4) + ((opcode == OP_JAL) ? imm_j : imm_b);
                case (opcode)
                    OP_SW:   imm_d = imm_s;
                    OP_LUI:  imm_d = imm_u;
                    default: imm_d = imm_i;
                endcase
                illegal_d = (ir_q != EOF_WORD) && !supported;
            end
            S_EXEC: begin
                alu_d = alu_res;
                if (opcode == OP_BR) begin
                    retire = 1'b1;
                    if (br_taken) pc_d = tgt_q;
                end else if (opcode == OP_JAL) begin
                    retire = 1'b1;
                    pc_d   = tgt_q;
                    regs_d[rd] = pc_q;
                end
            end
            S_MEM: begin
                if (dmem_valid) begin
                    mdr_d  = dmem_rdata;
                    retire = (opcode == OP_SW);
                end
            end
            S_WB: begin
                retire     = 1'b1;
                regs_d[rd] = (opcode == OP_LW) ? mdr_q : alu_q;
            end
            default: ;
        endcase
        regs_d[0] = 32'h0;

        clk_cnt_d = clk_cnt_q;
        if (state_q != S_HALT && clk_cnt_q != {CNT_W{1'b1}}) clk_cnt_d = clk_cnt_q + 1'b1;
        instr_cnt_d = instr_cnt_q;
        if (retire && instr_cnt_q != {CNT_W{1'b1}}) instr_cnt_d = instr_cnt_q + 1'b1;
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC; ir_q <= '0; a_q <= '0; b_q <= '0; imm_q <= '0;
            tgt_q <= '0; alu_q <= '0; mdr_q <= '0; illegal_q <= 1'b0;
            clk_cnt_q <= '0; instr_cnt_q <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            pc_q <= pc_d; ir_q <= ir_d; a_q <= a_d; b_q <= b_d; imm_q <= imm_d;
            tgt_q <= tgt_d; alu_q <= alu_d; mdr_q <= mdr_d; illegal_q <= illegal_d;
            clk_cnt_q <= clk_cnt_d; instr_cnt_q <= instr_cnt_d;
            regs_q <= regs_d;
        end
    end

    assign imem_addr   = pc_q[IMEM_AW+1:2];
    assign dmem_addr   = alu_q[DMEM_AW+1:2];
    assign dmem_wdata  = b_q;
    assign illegal     = illegal_q;
    assign clock_count = clk_cnt_q;
    assign instr_cnt   = instr_cnt_q;
endmodule

// File: tb/tb_riscv_mc_core.sv
// tb/tb_riscv_mc_core.sv - directed self-checking bench for riscv_mc_core
module tb_riscv_mc_core;
    localparam logic [31:0] EOF = 32'hFFFF_FFFF;

    logic        clk, rst_n;
    logic        imem_req, imem_valid, dmem_req, dmem_we, dmem_valid, done, illegal;
    logic [9:0]  imem_addr, dmem_addr;
    logic [31:0] imem_rdata, dmem_wdata, dmem_rdata;
    logic [15:0] clock_count, instr_cnt;

    logic        imem2_req, imem2_valid, dmem2_req, dmem2_valid, done2, illegal2;
    logic        unused2_we;
    logic [9:0]  imem2_addr, unused2_daddr;
    logic [31:0] imem2_rdata, unused2_wdata, dmem2_rdata, inc_word;
    logic [3:0]  clock_count2, instr_cnt2;

    logic [31:0] imem [0:1023];
    logic [31:0] dmem [0:1023];
    int imem_wait, dmem_wait, i_cnt, d_cnt, d_run, d_run_max;
    int n_checks, n_fail;

    riscv_mc_core dut (
        .CLOCK_50(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_valid(dmem_valid), .done(done), .illegal(illegal),
        .clock_count(clock_count), .instr_cnt(instr_cnt)
    );

    riscv_mc_core #(.CNT_W(4)) dut2 (
        .CLOCK_50(clk), .rst_n(rst_n),
        .imem_req(imem2_req), .imem_addr(imem2_addr), .imem_rdata(imem2_rdata), .imem_valid(imem2_valid),
        .dmem_req(dmem2_req), .dmem_we(unused2_we), .dmem_addr(unused2_daddr), .dmem_wdata(unused2_wdata),
        .dmem_rdata(dmem2_rdata), .dmem_valid(dmem2_valid), .done(done2), .illegal(illegal2),
        .clock_count(clock_count2), .instr_cnt(instr_cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign imem_valid  = imem_req && (i_cnt >= imem_wait);
    assign dmem_valid  = dmem_req && (d_cnt >= dmem_wait);
    assign imem_rdata  = imem[imem_addr];
    assign dmem_rdata  = dmem[dmem_addr];
    assign imem2_valid = imem2_req;
    assign dmem2_valid = dmem2_req;
    assign dmem2_rdata = 32'h0;
    assign imem2_rdata = (imem2_addr < 10'd20) ? inc_word : EOF;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_cnt <= 0;
            d_cnt <= 0;
        end else begin
            i_cnt <= (imem_req && !imem_valid) ? i_cnt + 1 : 0;
            d_cnt <= (dmem_req && !dmem_valid) ? d_cnt + 1 : 0;
            if (dmem_req && dmem_we && dmem_valid) dmem[dmem_addr] <= dmem_wdata;
        end
    end

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_run <= 0;
            d_run_max <= 0;
        end else if (dmem_req) begin
            d_run <= d_run + 1;
            if (d_run + 1 > d_run_max) d_run_max <= d_run + 1;
        end else begin
            d_run <= 0;
        end
    end

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int rd);
        return {imm[11:0], rs1[4:0], 3'b000, rd[4:0], 7'b0010011};
    endfunction
    function automatic logic [31:0] enc_lw(input int imm, input int rs1, input int rd);
        return {imm[11:0], rs1[4:0], 3'b010, rd[4:0], 7'b0000011};
    endfunction
    function automatic logic [31:0] enc_sw(input int imm, input int rs2, input int rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(input int imm20, input int rd);
        return {imm20[19:0], rd[4:0], 7'b0110111};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction

    task automatic enter_reset(input int iw, input int dw);
        @(negedge clk);
        rst_n = 1'b0;
        imem_wait = iw;
        dmem_wait = dw;
        for (int i = 0; i < 1024; i++) imem[i] = EOF;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input int limit, output int cycles);
        cycles = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (done) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if ({imem_req, dmem_req, dmem_we, done, illegal} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {imem_req, dmem_req, dmem_we, done, illegal}); end
        n_checks++; if ({clock_count, instr_cnt, imem_addr, dmem_addr, dmem_wdata} !== '0) begin n_fail++; $display("FAIL reset_data: cc=%0d ic=%0d ia=%0d da=%0d wd=%h want all 0", clock_count, instr_cnt, imem_addr, dmem_addr, dmem_wdata); end
    endtask

    task automatic test_alu_lui();
        int cyc;
        enter_reset(0, 0);
        imem[0] = enc_i(5, 0, 1);
        imem[1] = enc_i(-3, 0, 2);
        imem[2] = enc_r(1, 2, 1, 0, 3);
        imem[3] = enc_r(32, 2, 1, 0, 4);
        imem[4] = enc_u(20'h12345, 5);
        release_reset();
        wait_done(100, cyc);
        n_checks++; if (cyc < 0) begin n_fail++; $display("FAIL alu_done: done=%b want 1", done); end
        n_checks++; if (dut.regs_q[3] !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL alu_mul: got %h want fffffff1", dut.regs_q[3]); end
        n_checks++; if (dut.regs_q[4] !== 32'd8) begin n_fail++; $display("FAIL alu_sub: got %h want 8", dut.regs_q[4]); end
        n_checks++; if (dut.regs_q[5] !== 32'h1234_5000) begin n_fail++; $display("FAIL alu_lui: got %h want 12345000", dut.regs_q[5]); end
        n_checks++; if (instr_cnt !== 16'd5) begin n_fail++; $display("FAIL alu_icnt: got %0d want 5", instr_cnt); end
        n_checks++; if (clock_count !== 16'd22) begin n_fail++; $display("FAIL alu_ccnt: got %0d want 22", clock_count); end
        n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL alu_illegal: got %b want 0", illegal); end
    endtask

    task automatic test_logic();
        int cyc;
        enter_reset(0, 0);
        imem[0] = enc_i(5, 0, 1);
        imem[1] = enc_i(-3, 0, 2);
        imem[2] = enc_r(0, 2, 1, 7, 6);
        imem[3] = enc_r(0, 2, 1, 6, 7);
        imem[4] = enc_r(0, 1, 2, 2, 8);
        imem[5] = enc_r(0, 2, 1, 2, 9);
        imem[6] = enc_r(0, 2, 1, 0, 10);
        release_reset();
        wait_done(100, cyc);
        n_checks++; if (cyc < 0) begin n_fail++; $display("FAIL logic_done: done=%b want 1", done); end
        n_checks++; if (dut.regs_q[6] !== 32'd5) begin n_fail++; $display("FAIL logic_and: got %h want 5", dut.regs_q[6]); end
        n_checks++; if (dut.regs_q[7] !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL logic_or: got %h want fffffffd", dut.regs_q[7]); end
        n_checks++; if (dut.regs_q[8] !== 32'd1) begin n_fail++; $display("FAIL logic_slt_t: got %h want 1", dut.regs_q[8]); end
        n_checks++; if (dut.regs_q[9] !== 32'd0) begin n_fail++; $display("FAIL logic_slt_f: got %h want 0", dut.regs_q[9]); end
        n_checks++; if (dut.regs_q[10] !== 32'd2) begin n_fail++; $display("FAIL logic_add: got %h want 2", dut.regs_q[10]); end
    endtask

    task automatic test_load_store(input int waits, input int hi, input int lo, input int baddr,
                                   input logic [31:0] expv, input int expaddr, input int expclk);
        int cyc;
        logic [9:0] seen_addr;
        enter_reset(0, waits);
        imem[0] = enc_u(hi, 10);
        imem[1] = enc_i(lo, 10, 10);
        imem[2] = enc_sw(baddr, 10, 0);
        imem[3] = enc_lw(baddr, 0, 6);
        release_reset();
        seen_addr = '1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (dmem_req) seen_addr = dmem_addr;
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ls_done w%0d: done=%b want 1", waits, done); end
        n_checks++; if (seen_addr !== expaddr[9:0]) begin n_fail++; $display("FAIL ls_addr w%0d: got %0d want %0d", waits, seen_addr, expaddr); end
        n_checks++; if (dmem[expaddr] !== expv) begin n_fail++; $display("FAIL ls_mem w%0d: got %h want %h", waits, dmem[expaddr], expv); end
        n_checks++; if (dut.regs_q[6] !== expv) begin n_fail++; $display("FAIL ls_lw w%0d: got %h want %h", waits, dut.regs_q[6], expv); end
        n_checks++; if (clock_count !== expclk[15:0]) begin n_fail++; $display("FAIL ls_ccnt w%0d: got %0d want %0d", waits, clock_count, expclk); end
        n_checks++; if (d_run_max !== waits + 1) begin n_fail++; $display("FAIL ls_reqlen w%0d: got %0d want %0d", waits, d_run_max, waits + 1); end
    endtask

    task automatic test_branch();
        int cyc;
        enter_reset(0, 0);
        imem[0]  = enc_i(4, 0, 1);
        imem[1]  = enc_i(0, 0, 2);
        imem[2]  = enc_i(1, 2, 2);
        imem[3]  = enc_i(-1, 1, 1);
        imem[4]  = enc_b(-8, 0, 1, 1);
        imem[5]  = enc_i(0, 0, 3);
        imem[6]  = enc_i(4, 0, 4);
        imem[7]  = enc_i(1, 3, 3);
        imem[8]  = enc_b(-4, 4, 3, 4);
        imem[9]  = enc_i(1, 0, 6);
        imem[10] = enc_i(0, 0, 5);
        imem[11] = enc_i(1, 5, 5);
        imem[12] = enc_b(-4, 6, 5, 0);
        imem[13] = enc_j(8, 7);
        imem[14] = enc_i(99, 0, 8);
        imem[15] = enc_i(7, 0, 0);
        imem[16] = enc_r(0, 5, 0, 0, 9);
        release_reset();
        wait_done(500, cyc);
        n_checks++; if (cyc < 0) begin n_fail++; $display("FAIL br_done: done=%b want 1", done); end
        n_checks++; if (dut.regs_q[2] !== 32'd4) begin n_fail++; $display("FAIL br_bne_iter: got %0d want 4", dut.regs_q[2]); end
        n_checks++; if (dut.regs_q[3] !== 32'd4) begin n_fail++; $display("FAIL br_blt_iter: got %0d want 4", dut.regs_q[3]); end
        n_checks++; if (dut.regs_q[5] !== 32'd2) begin n_fail++; $display("FAIL br_beq_back: got %0d want 2", dut.regs_q[5]); end
        n_checks++; if (dut.regs_q[7] !== 32'd56) begin n_fail++; $display("FAIL br_jal_link: got %0d want 56", dut.regs_q[7]); end
        n_checks++; if (dut.regs_q[8] !== 32'd0) begin n_fail++; $display("FAIL br_jal_skip: got %0d want 0", dut.regs_q[8]); end
        n_checks++; if (dut.regs_q[9] !== 32'd2) begin n_fail++; $display("FAIL br_x0_read: got %0d want 2", dut.regs_q[9]); end
        n_checks++; if (instr_cnt !== 16'd33) begin n_fail++; $display("FAIL br_icnt: got %0d want 33", instr_cnt); end
        n_checks++; if (clock_count !== 16'd123) begin n_fail++; $display("FAIL br_ccnt: got %0d want 123", clock_count); end
    endtask

    task automatic test_halt();
        int cyc;
        enter_reset(0, 0);
        release_reset();
        wait_done(20, cyc);
        n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL halt_cycle: done after %0d cycles want 2", cyc); end
        n_checks++; if (clock_count !== 16'd2 || instr_cnt !== 16'd0) begin n_fail++; $display("FAIL halt_cnt: cc=%0d ic=%0d want 2 0", clock_count, instr_cnt); end
        repeat (50) @(negedge clk);
        n_checks++; if (clock_count !== 16'd2 || instr_cnt !== 16'd0) begin n_fail++; $display("FAIL halt_hold: cc=%0d ic=%0d want 2 0", clock_count, instr_cnt); end
        n_checks++; if ({imem_req, dmem_req, done, illegal} !== 4'b0010) begin n_fail++; $display("FAIL halt_outs: got %b want 0010", {imem_req, dmem_req, done, illegal}); end
    endtask

    task automatic test_illegal();
        int cyc;
        enter_reset(0, 0);
        imem[0] = 32'h0000_007F;
        release_reset();
        wait_done(20, cyc);
        n_checks++; if (cyc !== 2 || illegal !== 1'b1) begin n_fail++; $display("FAIL ill_opcode: cycles=%0d illegal=%b want 2 1", cyc, illegal); end
        enter_reset(0, 0);
        imem[0] = enc_i(1, 0, 1);
        imem[1] = enc_r(0, 2, 1, 1, 3);
        release_reset();
        wait_done(40, cyc);
        n_checks++; if (cyc !== 6 || illegal !== 1'b1) begin n_fail++; $display("FAIL ill_funct: cycles=%0d illegal=%b want 6 1", cyc, illegal); end
        n_checks++; if (instr_cnt !== 16'd1) begin n_fail++; $display("FAIL ill_icnt: got %0d want 1", instr_cnt); end
    endtask

    task automatic test_reset_midreq();
        int cyc;
        enter_reset(0, 10);
        imem[0] = enc_i(85, 0, 1);
        imem[1] = enc_sw(20, 1, 0);
        release_reset();
        for (int i = 0; i < 50 && !dmem_req; i++) @(negedge clk);
        n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL mid_req_seen: dmem_req=%b want 1", dmem_req); end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({imem_req, dmem_req, dmem_we, done, illegal} !== 5'b0) begin n_fail++; $display("FAIL mid_ctrl: got %b want 00000", {imem_req, dmem_req, dmem_we, done, illegal}); end
        n_checks++; if ({clock_count, instr_cnt, imem_addr, dmem_addr, dmem_wdata} !== '0) begin n_fail++; $display("FAIL mid_data: cc=%0d ic=%0d ia=%0d da=%0d wd=%h want all 0", clock_count, instr_cnt, imem_addr, dmem_addr, dmem_wdata); end
        dmem_wait = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin n_fail++; $display("FAIL mid_restart: req=%b addr=%0d want 1 0", imem_req, imem_addr); end
        wait_done(100, cyc);
        n_checks++; if (cyc !== 10 || instr_cnt !== 16'd2) begin n_fail++; $display("FAIL mid_rerun: cycles=%0d ic=%0d want 10 2", cyc, instr_cnt); end
        n_checks++; if (dmem[5] !== 32'd85) begin n_fail++; $display("FAIL mid_store: got %h want 55", dmem[5]); end
    endtask

    task automatic test_saturation();
        enter_reset(0, 0);
        release_reset();
        for (int i = 0; i < 300 && !done2; i++) @(negedge clk);
        n_checks++; if (done2 !== 1'b1 || illegal2 !== 1'b0) begin n_fail++; $display("FAIL sat_done: done=%b illegal=%b want 1 0", done2, illegal2); end
        n_checks++; if (instr_cnt2 !== 4'd15) begin n_fail++; $display("FAIL sat_icnt: got %0d want 15", instr_cnt2); end
        n_checks++; if (clock_count2 !== 4'd15) begin n_fail++; $display("FAIL sat_ccnt: got %0d want 15", clock_count2); end
        n_checks++; if (dut2.regs_q[1] !== 32'd20) begin n_fail++; $display("FAIL sat_x1: got %0d want 20", dut2.regs_q[1]); end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        imem_wait = 0;
        dmem_wait = 0;
        inc_word = enc_i(1, 1, 1);
        for (int i = 0; i < 1024; i++) imem[i] = EOF;
        test_reset();
        test_alu_lui();
        test_logic();
        test_load_store(0, 20'hDEADC, -273, 12, 32'hDEAD_BEEF, 3, 19);
        test_load_store(3, 20'h12345, 1656, 16, 32'h1234_5678, 4, 25);
        test_branch();
        test_halt();
        test_illegal();
        test_reset_midreq();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
